// File: rtl/wb_write_arbiter.sv
// Write-back arbiter for the dual-issue pipeline: serializes conflicting slot
// writes onto the single register-file port and merges NZCV updates in order.
module wb_write_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr1_en,
    input  logic [2:0]       wr1_rd,
    input  logic [31:0]      wr1_data,
    input  logic             wr2_en,
    input  logic [2:0]       wr2_rd,
    input  logic [31:0]      wr2_data,
    input  logic [3:0]       flag1_val,
    input  logic [3:0]       flag1_en,
    input  logic [3:0]       flag2_val,
    input  logic [3:0]       flag2_en,
    output logic             rf_we,
    output logic [2:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [3:0]       flag_we,
    output logic [3:0]       flag_wdata,
    output logic             stall,
    output logic [CNT_W-1:0] ser_count
);

    typedef enum logic {
        IDLE,
        SECOND
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        conflict;
    logic        capture;
    logic [3:0]  merge_we;
    logic [3:0]  merge_val;

    logic [2:0]  hold_rd;
    logic [31:0] hold_data;
    logic [3:0]  hold_fwe;
    logic [3:0]  hold_fval;

    // Slot 2 is younger, so its flag bits override slot 1 where both update.
    assign merge_we  = flag1_en | flag2_en;
    assign merge_val = (flag2_en & flag2_val) | (~flag2_en & flag1_val);

    assign conflict = wr1_en & wr2_en & (wr1_rd != wr2_rd);
    assign capture  = (state == IDLE) & conflict;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            IDLE: begin
                if (conflict) begin
                    state_nxt = SECOND;
                end
            end
            SECOND: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_rd   <= '0;
            hold_data <= '0;
            hold_fwe  <= '0;
            hold_fval <= '0;
        end else if (capture) begin
            hold_rd   <= wr2_rd;
            hold_data <= wr2_data;
            hold_fwe  <= merge_we;
            hold_fval <= merge_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ser_count <= '0;
        end else if (capture && (ser_count != '1)) begin
            ser_count <= ser_count + CNT_W'(1);
        end
    end

    always_comb begin
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        flag_we    = '0;
        flag_wdata = '0;
        stall      = 1'b0;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    if (conflict) begin
                        rf_we    = 1'b1;
                        rf_waddr = wr1_rd;
                        rf_wdata = wr1_data;
                        stall    = 1'b1;
                    end else begin
                        flag_we    = merge_we;
                        flag_wdata = merge_val;
                        if (wr2_en) begin
                            rf_we    = 1'b1;
                            rf_waddr = wr2_rd;
                            rf_wdata = wr2_data;
                        end else if (wr1_en) begin
                            rf_we    = 1'b1;
                            rf_waddr = wr1_rd;
                            rf_wdata = wr1_data;
                        end
                    end
                end
                SECOND: begin
                    rf_we      = 1'b1;
                    rf_waddr   = hold_rd;
                    rf_wdata   = hold_data;
                    flag_we    = hold_fwe;
                    flag_wdata = hold_fval;
                end
                default: begin
                    rf_we = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: expected writes queued per pair,
// compared as the arbiter presents them; a CNT_W=2 copy covers saturation.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr1_en, wr2_en;
    logic [2:0]  wr1_rd, wr2_rd;
    logic [31:0] wr1_data, wr2_data;
    logic [3:0]  flag1_val, flag1_en, flag2_val, flag2_en;

    logic        rf_we, stall;
    logic [2:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  flag_we, flag_wdata;
    logic [15:0] ser_count;

    logic        s_rf_we, s_stall;
    logic [2:0]  s_rf_waddr;
    logic [31:0] s_rf_wdata;
    logic [3:0]  s_flag_we, s_flag_wdata;
    logic [1:0]  s_ser_count;

    typedef struct packed {
        logic        we;
        logic [2:0]  rd;
        logic [31:0] data;
        logic [3:0]  fwe;
        logic [3:0]  fval;
    } wr_t;

    wr_t sb[$];
    int  errors = 0;
    int  checks = 0;
    int  exp_cnt = 0;

    always #5 clk = ~clk;

    wb_write_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .wr1_en(wr1_en), .wr1_rd(wr1_rd), .wr1_data(wr1_data),
        .wr2_en(wr2_en), .wr2_rd(wr2_rd), .wr2_data(wr2_data),
        .flag1_val(flag1_val), .flag1_en(flag1_en),
        .flag2_val(flag2_val), .flag2_en(flag2_en),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_we(flag_we), .flag_wdata(flag_wdata),
        .stall(stall), .ser_count(ser_count)
    );

    wb_write_arbiter #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset),
        .wr1_en(wr1_en), .wr1_rd(wr1_rd), .wr1_data(wr1_data),
        .wr2_en(wr2_en), .wr2_rd(wr2_rd), .wr2_data(wr2_data),
        .flag1_val(flag1_val), .flag1_en(flag1_en),
        .flag2_val(flag2_val), .flag2_en(flag2_en),
        .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
        .flag_we(s_flag_we), .flag_wdata(s_flag_wdata),
        .stall(s_stall), .ser_count(s_ser_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: queue the writes one MEM/WB pair should produce.
    task automatic expect_pair(output logic conf);
        logic [3:0]  mwe;
        logic [3:0]  mval;
        logic        we;
        logic [2:0]  rd;
        logic [31:0] data;
        for (int i = 0; i < 4; i++) begin
            mwe[i]  = flag1_en[i] | flag2_en[i];
            mval[i] = flag2_en[i] ? flag2_val[i] : flag1_val[i];
        end
        conf = wr1_en && wr2_en && (wr1_rd != wr2_rd);
        if (conf) begin
            sb.push_back('{1'b1, wr1_rd, wr1_data, 4'b0, 4'b0});
            sb.push_back('{1'b1, wr2_rd, wr2_data, mwe, mval});
        end else begin
            we   = wr1_en | wr2_en;
            rd   = wr2_en ? wr2_rd : (wr1_en ? wr1_rd : 3'd0);
            data = wr2_en ? wr2_data : (wr1_en ? wr1_data : 32'd0);
            if (we || (mwe != 4'b0)) begin
                sb.push_back('{we, rd, data, mwe, mval});
            end
        end
    endtask

    task automatic set_in(input logic e1, input logic [2:0] r1,
                          input logic [31:0] d1, input logic e2,
                          input logic [2:0] r2, input logic [31:0] d2,
                          input logic [3:0] f1e, input logic [3:0] f1v,
                          input logic [3:0] f2e, input logic [3:0] f2v);
        wr1_en = e1; wr1_rd = r1; wr1_data = d1;
        wr2_en = e2; wr2_rd = r2; wr2_data = d2;
        flag1_en = f1e; flag1_val = f1v;
        flag2_en = f2e; flag2_val = f2v;
    endtask

    // Called just after a rising edge; inputs held while the arbiter stalls.
    task automatic run_pair();
        logic conf;
        expect_pair(conf);
        if (conf) exp_cnt++;
        @(negedge clk);
        check("stall_c0", stall, conf);
        if (conf) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("stall_c1", stall, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (reset && (rf_we || (flag_we != 4'b0))) begin
            if (sb.size() == 0) begin
                check("unexpected_wr", {rf_we, flag_we}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rf_we", rf_we, e.we);
                if (e.we) begin
                    check("rf_waddr", rf_waddr, e.rd);
                    check("rf_wdata", rf_wdata, e.data);
                end
                check("flag_we", flag_we, e.fwe);
                check("flag_wdata", flag_wdata & e.fwe, e.fval & e.fwe);
            end
        end
    end

    initial begin
        set_in(1, 3'd1, 32'h1, 1, 3'd2, 32'h2, 4'hF, 4'h5, 4'hF, 4'hA);
        @(negedge clk);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_flag_we", flag_we, 4'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_cnt", ser_count, 16'd0);
        @(posedge clk);
        #1;
        check("rst_cnt_hold", ser_count, 16'd0);
        reset = 1'b1;
        run_pair();
        check("cnt_first", ser_count, exp_cnt);

        set_in(1, 3'd3, 32'h11, 0, 3'd0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        run_pair();
        set_in(0, 3'd0, 32'h0, 1, 3'd5, 32'hFF, 4'h0, 4'h0, 4'h0, 4'h0);
        run_pair();

        set_in(1, 3'd2, 32'hAAAA0000, 1, 3'd6, 32'h000000BB,
               4'b1100, 4'b1000, 4'b0010, 4'b0010);
        run_pair();
        check("cnt_conflict", ser_count, exp_cnt);

        set_in(1, 3'd4, 32'h1, 1, 3'd4, 32'h2, 4'h0, 4'h0, 4'h0, 4'h0);
        run_pair();
        check("cnt_same_rd", ser_count, exp_cnt);

        set_in(0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 4'b1001, 4'b0001, 4'b0001, 4'b0000);
        run_pair();
        set_in(0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        run_pair();

        // Reset while the slot-2 write is pending.
        set_in(1, 3'd1, 32'h1234, 1, 3'd7, 32'h5678, 4'hF, 4'h0, 4'h0, 4'h0);
        sb.push_back('{1'b1, 3'd1, 32'h1234, 4'b0, 4'b0});
        @(negedge clk);
        check("mid_stall", stall, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rf_we", rf_we, 1'b0);
        check("mid_flag_we", flag_we, 4'b0);
        check("mid_cnt", ser_count, 16'd0);
        set_in(0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        exp_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_no_slot2", rf_we, 1'b0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 3; k++) begin
            set_in(1, 3'(k), 32'h100 + k, 1, 3'(k + 4), 32'h200 + k,
                   4'h3, 4'h1, 4'h4, 4'h4);
            run_pair();
        end
        check("cnt_b2b", ser_count, 16'd3);

        for (int k = 0; k < 30; k++) begin
            set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            run_pair();
        end
        check("cnt_random", ser_count, exp_cnt);

        set_in(0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            set_in(1, 3'd1, 32'h10 + k, 1, 3'd2, 32'h20 + k,
                   4'h0, 4'h0, 4'h0, 4'h0);
            run_pair();
            check("sat_cnt", s_ser_count, (k < 3) ? k + 1 : 3);
            check("sat_main_cnt", ser_count, k + 1);
        end

        set_in(0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-back port arbiter for the dual-issue pipeline. It sits between the MEM/WB pipeline register outputs and the single-write-port register file / NZCV flag register. When both issue slots write different destination registers in the same cycle, it serializes the writes over two cycles and stalls the MEM/WB register. It also merges the per-slot flag updates in program order, where slot 1 is older than slot 2.

## Interface
Parameters:
- CNT_W, 16, width of the serialization event counter

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-low reset
- wr1_en  input  1  slot-1 register write enable (MEM/WB P4_regWrite1)
- wr1_rd  input  3  slot-1 destination register
- wr1_data  input  32  slot-1 write data (ALU result)
- wr2_en  input  1  slot-2 register write enable (MEM/WB P4_regWrite2)
- wr2_rd  input  3  slot-2 destination register
- wr2_data  input  32  slot-2 write data (zero-extended memory data)
- flag1_val  input  4  slot-1 flag values {N,Z,C,V}
- flag1_en  input  4  slot-1 per-flag update signals {N,Z,C,V}
- flag2_val  input  4  slot-2 flag values
- flag2_en  input  4  slot-2 per-flag update signals
- rf_we  output  1  register file write enable
- rf_waddr  output  3  register file write address
- rf_wdata  output  32  register file write data
- flag_we  output  4  per-flag write enable
- flag_wdata  output  4  flag write data
- stall  output  1  hold request; when high, the MEM/WB (and upstream) register write enable must be deasserted
- ser_count  output  CNT_W  number of serialized pairs since reset (saturating)

## Operation
- Two states: IDLE and SECOND.
- IDLE, case by case (outputs combinational from the inputs):
  - Neither enable set: rf_we=0.
  - Exactly one enable set: write that slot (rf_we=1, addr/data from that slot); stall=0.
  - Both set, wr1_rd==wr2_rd: single write of slot 2 (younger wins); slot 1 is dropped; stall=0.
  - Both set, rds differ: write slot 1 this cycle; stall=1.
  - Also on a both-set-rds-differ edge: capture wr2_rd, wr2_data and the merged flags into hold registers; go to SECOND.
- Flag merge, per bit i:
  - flag_wdata[i] = flag2_en[i] ? flag2_val[i] : flag1_val[i]
  - flag_we[i] = flag1_en[i] | flag2_en[i]
  - Flags are written in the final cycle of a pair only. In IDLE with no serialization, they are written in that same cycle. In the serialized case, flag_we=0 in the IDLE cycle.
- SECOND:
  - Outputs come from the hold registers: rf_we=1, rf_waddr=hold_rd, rf_wdata=hold_data, flag_we/flag_wdata = held merged flags.
  - stall=0.
  - Live inputs are ignored (they still show the held pair).
  - Next state is always IDLE.
- ser_count: increments by 1 on each IDLE→SECOND transition and saturates at all-ones.

## Timing
- Reset (reset=0, asynchronous):
  - State=IDLE; hold registers and ser_count = 0.
  - While reset is low, rf_we, flag_we and stall are forced to 0 regardless of inputs.
  - Reset in SECOND abandons the pending slot-2 write; no write occurs after reset releases.
- Non-conflicting pair: latency 0. Writes are presented in the same cycle the MEM/WB outputs are valid; throughput is 1 pair per cycle.
- Conflicting pair takes 2 cycles:
  - Cycle 0 (IDLE): slot-1 write, stall=1.
  - Cycle 1 (SECOND): slot-2 write plus flags, stall=0.
  - The MEM/WB register advances at the end of cycle 1.
- stall is never high for two consecutive cycles; it is never high in SECOND.
- Write order to the register file is always slot 1, then slot 2.
- rf_* and flag_* are valid as combinational outputs to be sampled by the register file on the next rising clk edge.

## Test plan
- Reset hold: reset=0 with wr1_en=wr2_en=1 and rds 1/2 → rf_we=0, flag_we=0, stall=0, ser_count=0. After release, the first IDLE cycle behaves normally.
- Single writes:
  - wr1_en=1, wr1_rd=3, wr1_data=0x11 → rf_we=1, addr 3, data 0x11, stall=0.
  - Next cycle wr2_en=1, wr2_rd=5, wr2_data=0xFF → addr 5, data 0xFF.
- Conflict pair: wr1 (rd=2, 0xAAAA0000), wr2 (rd=6, 0x000000BB), flag1_en=4'b1100, flag1_val=4'b1000, flag2_en=4'b0010, flag2_val=4'b0010. Required response:
  - Cycle 0: write r2=0xAAAA0000, stall=1, flag_we=0.
  - Cycle 1: write r6=0x000000BB, flag_we=4'b1110, flag_wdata=4'b1010, stall=0.
  - ser_count=1.
- Same destination: both enabled, rd=4, data 0x1 / 0x2 → exactly one write, r4=0x2, stall=0, ser_count unchanged.
- Reset mid-operation: assert reset in SECOND → no slot-2 write, state IDLE, ser_count=0. Back-to-back conflicting pairs for 3 pairs → stall pattern 1,0,1,0,1,0 and ser_count=3.
- Saturation: CNT_W=2, 5 conflicting pairs → ser_count = 1,2,3,3,3.
